// File: rtl/sram_ctrl_nbeat.sv
// sram_ctrl_nbeat: splits DATA_W-bit LSU requests into 16-bit beats on an async SRAM
module sram_ctrl_nbeat #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18,
    parameter int RD_CYC = 2,
    parameter int WR_CYC = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [ADDR_W-1:0]   i_ADDR,
    input  logic [DATA_W-1:0]   i_WDATA,
    input  logic [DATA_W/8-1:0] i_BMASK,
    input  logic                i_WREN,
    input  logic                i_RDEN,
    output logic [DATA_W-1:0]   o_RDATA,
    output logic                o_ACK,
    output logic                o_READY,
    output logic                o_ERR,
    output logic [ADDR_W-1:0]   SRAM_ADDR,
    inout  wire  [15:0]         SRAM_DQ,
    output logic                SRAM_CE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_UB_N
);
    localparam int NBEAT = DATA_W / 16;
    localparam int MW = DATA_W / 8;
    localparam int BW = NBEAT > 1 ? $clog2(NBEAT) : 1;
    localparam int MAXC = RD_CYC > WR_CYC ? RD_CYC : WR_CYC;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(NBEAT - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);
    localparam logic [DATA_W-1:0] LANE = DATA_W'(16'hFFFF);

    typedef enum logic [1:0] {IDLE, WBEAT, RBEAT, ACK} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]       mask_q, mask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [BW+3:0]       sh;
    logic [1:0]          lane;
    logic [15:0]         wbeat, rbeat;
    logic                in_beat, active, last_cyc;

    assign sh       = {beat_q, 4'b0};
    assign lane     = 2'(mask_q >> {beat_q, 1'b0});
    assign wbeat    = 16'(wdata_q >> sh);
    assign rbeat    = {lane[1] ? SRAM_DQ[15:8] : 8'h00, lane[0] ? SRAM_DQ[7:0] : 8'h00};
    assign in_beat  = state_q == WBEAT || state_q == RBEAT;
    assign active   = in_beat && |lane;
    assign last_cyc = cyc_q == CW'((state_q == WBEAT ? WR_CYC : RD_CYC) - 1);

    assign SRAM_ADDR = addr_q | ADDR_W'(beat_q);
    assign SRAM_CE_N = ~active;
    assign SRAM_WE_N = ~(active && state_q == WBEAT);
    assign SRAM_OE_N = ~(active && state_q == RBEAT);
    assign SRAM_UB_N = ~(in_beat && lane[1]);
    assign SRAM_LB_N = ~(in_beat && lane[0]);
    assign SRAM_DQ   = state_q == WBEAT ? wbeat : 16'hzzzz;
    assign o_READY   = state_q == IDLE || state_q == ACK;
    assign o_ACK     = state_q == ACK;
    assign o_ERR     = err_q;
    assign o_RDATA   = rdata_q;

    // Next state: accept/reject requests when ready, step cycle and beat counters otherwise
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            WBEAT, RBEAT: begin
                cyc_d = last_cyc ? '0 : cyc_q + 1'b1;
                if (last_cyc && state_q == RBEAT)
                    rdata_d = (rdata_q & ~(LANE << sh)) | (DATA_W'(rbeat) << sh);
                if (last_cyc && beat_q == LAST_BEAT)
                    state_d = ACK;
                else if (last_cyc)
                    beat_d = beat_q + 1'b1;
            end
            default: begin
                err_d   = i_WREN && i_RDEN;
                state_d = i_WREN ^ i_RDEN ? (i_WREN ? WBEAT : RBEAT) : IDLE;
                if (i_WREN ^ i_RDEN) begin
                    addr_d  = i_ADDR & ALIGN;
                    wdata_d = i_WDATA;
                    mask_d  = i_BMASK;
                    beat_d  = '0;
                    cyc_d   = '0;
                end
            end
        endcase
    end

    // State and datapath registers, cleared immediately by the asynchronous reset
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cyc_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule
